// File: rtl/alu_sequencer_if.sv
// Command/response/ALU bundle for alu_sequencer.
// Optional ALU_SEQ_FLAGS_EN adds the rsp_zero/rsp_neg response flags.
interface alu_seq_if #(
    parameter int DATA_W = 6,
    parameter int RA_W   = 2
);
    // Valid/ready: a transfer happens on the rising edge where valid and ready are both 1;
    // the sender holds its payload stable while valid=1 and ready=0.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [RA_W-1:0]   cmd_ra;
    logic [RA_W-1:0]   cmd_rb;
    logic [RA_W-1:0]   cmd_rd;
    logic              ld_en;
    logic [RA_W-1:0]   ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [3:0]        alu_sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_x;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic              rsp_zero;
    logic              rsp_neg;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, ld_en, ld_addr, ld_data,
        output alu_x, rsp_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err,
        input  rsp_zero, rsp_neg
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, ld_en, ld_addr, ld_data,
        input  alu_x, rsp_ready,
        output cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err,
        output rsp_zero, rsp_neg
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, ld_en, ld_addr, ld_data,
        output alu_x, rsp_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rd, ld_en, ld_addr, ld_data,
        input  alu_x, rsp_ready,
        output cmd_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// Sequences an external combinational ALU from a small register file, one command at a time.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg outputs.
module alu_sequencer #(
    parameter int DATA_W = 6,
    parameter int NREG   = 4,
    parameter int RA_W   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] regs [NREG];
    logic [RA_W-1:0]   rd_q;
    logic              op_illegal;
    logic              cmd_fire;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign op_illegal    = (bus.alu_sel == 4'b1101) || (bus.alu_sel == 4'b1110);
    assign dbg_state     = state;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are sampled with non-blocking reads, so a same-cycle load is not seen by them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            bus.alu_sel  <= 4'b0000;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            rd_q         <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            bus.rsp_zero <= 1'b0;
            bus.rsp_neg  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_en) regs[bus.ld_addr] <= bus.ld_data;
                    if (cmd_fire) begin
                        bus.alu_sel <= bus.cmd_op;
                        bus.alu_a   <= regs[bus.cmd_ra];
                        bus.alu_b   <= regs[bus.cmd_rb];
                        rd_q        <= bus.cmd_rd;
                    end
                end
                EXEC: begin
                    if (op_illegal) begin
                        bus.rsp_data <= '0;
                        bus.rsp_err  <= 1'b1;
                    end else begin
                        regs[rd_q]   <= bus.alu_x;
                        bus.rsp_data <= bus.alu_x;
                        bus.rsp_err  <= 1'b0;
                    end
`ifdef ALU_SEQ_FLAGS_EN
                    bus.rsp_zero <= op_illegal ? 1'b0 : (bus.alu_x == '0);
                    bus.rsp_neg  <= op_illegal ? 1'b0 : bus.alu_x[DATA_W-1];
`endif
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.alu_sel <= 4'b0000;
                        bus.alu_a   <= '0;
                        bus.alu_b   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table, hand-written corner sequences and
// randomized commands scored against an arithmetic register-file model.
module tb_alu_sequencer;
    localparam int DATA_W = 6;
    localparam int RA_W   = 2;
    localparam int NREG   = 4;
    localparam int MOD    = 1 << DATA_W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

    alu_sequencer #(.DATA_W(DATA_W), .NREG(NREG), .RA_W(RA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // The ALU that sits beside the sequencer; illegal selects give junk on purpose.
    always_comb begin
        bus.alu_x = '0;
        case (bus.alu_sel)
            4'b0000: bus.alu_x = '0;
            4'b0001: bus.alu_x = bus.alu_a;
            4'b0010: bus.alu_x = bus.alu_b;
            4'b0011: bus.alu_x = (bus.alu_a >= bus.alu_b) ? DATA_W'(1) : DATA_W'(0);
            4'b0100: bus.alu_x = -bus.alu_a;
            4'b0101: bus.alu_x = -bus.alu_b;
            4'b0110: bus.alu_x = {bus.alu_a[2:0], bus.alu_a[DATA_W-1:3]};
            4'b0111: bus.alu_x = {bus.alu_b[2:0], bus.alu_b[DATA_W-1:3]};
            4'b1000: bus.alu_x = bus.alu_a ^ bus.alu_b;
            4'b1001: bus.alu_x = ~bus.alu_a;
            4'b1010: bus.alu_x = ~bus.alu_b;
            4'b1011: bus.alu_x = bus.alu_a - bus.alu_b;
            4'b1100: bus.alu_x = bus.alu_a + bus.alu_b;
            4'b1111: bus.alu_x = '1;
            default: bus.alu_x = DATA_W'(42);
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int m_regs [NREG];
    logic [DATA_W:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file semantics from the command description, in plain integer arithmetic.
    task automatic ref_op(input logic [3:0] op, input int a, input int b, output int res, output bit err);
        err = 1'b0;
        res = 0;
        case (op)
            4'd0:  res = 0;
            4'd1:  res = a;
            4'd2:  res = b;
            4'd3:  res = (a >= b) ? 1 : 0;
            4'd4:  res = (MOD - a) % MOD;
            4'd5:  res = (MOD - b) % MOD;
            4'd6:  res = (a / 8) + (a % 8) * (MOD / 8);
            4'd7:  res = (b / 8) + (b % 8) * (MOD / 8);
            4'd8:  res = a ^ b;
            4'd9:  res = MOD - 1 - a;
            4'd10: res = MOD - 1 - b;
            4'd11: res = (a + MOD - b) % MOD;
            4'd12: res = (a + b) % MOD;
            4'd15: res = MOD - 1;
            default: err = 1'b1;
        endcase
    endtask

    task automatic load_reg(input int addr, input int data);
        bus.ld_en   = 1'b1;
        bus.ld_addr = RA_W'(addr);
        bus.ld_data = DATA_W'(data);
        @(negedge clk);
        bus.ld_en = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic send_cmd(input logic [3:0] op, input int ra, input int rb, input int rd,
                            input bit ld, input int la, input int ldd);
        int n = 0;
        int res;
        bit err;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ra    = RA_W'(ra);
        bus.cmd_rb    = RA_W'(rb);
        bus.cmd_rd    = RA_W'(rd);
        bus.ld_en     = ld;
        bus.ld_addr   = RA_W'(la);
        bus.ld_data   = DATA_W'(ldd);
        ref_op(op, m_regs[ra], m_regs[rb], res, err);
        if (ld) m_regs[la] = ldd;
        if (!err) m_regs[rd] = res;
        exp_q.push_back({err, DATA_W'(res)});
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.ld_en     = 1'b0;
        check("exec_no_rsp", bus.rsp_valid, 0);
        check("exec_busy", bus.cmd_ready, 0);
        @(negedge clk);
        check("rsp_latency", bus.rsp_valid, 1);
    endtask

    task automatic get_rsp(input int hold, output logic [DATA_W-1:0] d, output logic e);
        int n = 0;
        logic [DATA_W:0] exp;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_wait", bus.rsp_valid, 1);
        d = bus.rsp_data;
        e = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_data", bus.rsp_data, d);
            check("hold_err", bus.rsp_err, e);
            check("hold_busy", bus.cmd_ready, 0);
        end
        bus.ld_en = 1'b0;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got a response, expected none");
        end else begin
            exp = exp_q.pop_front();
            check("rsp_data", d, exp[DATA_W-1:0]);
            check("rsp_err", e, exp[DATA_W]);
`ifdef ALU_SEQ_FLAGS_EN
            check("rsp_zero", bus.rsp_zero, (exp[DATA_W-1:0] == 0) && !exp[DATA_W]);
            check("rsp_neg", bus.rsp_neg, exp[DATA_W-1] && !exp[DATA_W]);
`endif
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("rsp_cleared", bus.rsp_valid, 0);
        check("alu_sel_idle", bus.alu_sel, 0);
    endtask

    typedef struct {
        logic [3:0]        op;
        int                ra;
        int                rb;
        int                rd;
        logic [DATA_W-1:0] exp_d;
        logic              exp_e;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] d;
        logic              e;
        vecs[0]  = '{4'b1100, 0, 1, 2, 6'd8,  1'b0};
        vecs[1]  = '{4'b0001, 2, 0, 3, 6'd8,  1'b0};
        vecs[2]  = '{4'b1011, 0, 1, 3, 6'd2,  1'b0};
        vecs[3]  = '{4'b0100, 0, 1, 3, 6'd59, 1'b0};
        vecs[4]  = '{4'b0110, 0, 1, 3, 6'd40, 1'b0};
        vecs[5]  = '{4'b0011, 0, 1, 3, 6'd1,  1'b0};
        vecs[6]  = '{4'b0011, 1, 0, 3, 6'd0,  1'b0};
        vecs[7]  = '{4'b1000, 0, 1, 3, 6'd6,  1'b0};
        vecs[8]  = '{4'b1111, 0, 1, 3, 6'd63, 1'b0};
        vecs[9]  = '{4'b0000, 0, 1, 3, 6'd0,  1'b0};
        vecs[10] = '{4'b0101, 0, 1, 3, 6'd61, 1'b0};
        vecs[11] = '{4'b0111, 0, 1, 3, 6'd24, 1'b0};
        vecs[12] = '{4'b1001, 0, 1, 3, 6'd58, 1'b0};
        vecs[13] = '{4'b1010, 0, 1, 3, 6'd60, 1'b0};
        vecs[14] = '{4'b0010, 0, 1, 3, 6'd3,  1'b0};

        // Clock/reset
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ra = '0; bus.cmd_rb = '0; bus.cmd_rd = '0;
        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < NREG; i++) m_regs[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_alu_sel", bus.alu_sel, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table on R0=5, R1=3
        load_reg(0, 5);
        load_reg(1, 3);
        for (int i = 0; i < 15; i++) begin
            send_cmd(vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].rd, 1'b0, 0, 0);
            get_rsp(0, d, e);
            check("vec_data", d, vecs[i].exp_d);
            check("vec_err", e, vecs[i].exp_e);
        end

        // Wrap-around with full aliasing of the destination
        load_reg(0, 63);
        load_reg(1, 1);
        send_cmd(4'b1100, 0, 1, 0, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("wrap_data", d, 0);
        send_cmd(4'b0001, 0, 0, 3, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("wrap_r0", d, 0);

        // Illegal opcodes leave the destination untouched
        load_reg(1, 3);
        send_cmd(4'b1101, 0, 0, 1, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("illegal_err", e, 1);
        check("illegal_data", d, 0);
        send_cmd(4'b1110, 1, 1, 1, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("illegal2_err", e, 1);
        send_cmd(4'b0001, 1, 0, 3, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("illegal_r1_kept", d, 3);

        // Load in the accept cycle: operands see the old value
        load_reg(0, 5);
        send_cmd(4'b0001, 0, 0, 3, 1'b1, 0, 10);
        get_rsp(0, d, e);
        check("preload_operand", d, 5);
        send_cmd(4'b0001, 0, 0, 3, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("postload_value", d, 10);

        // Backpressure with a load attempted during RESP
        send_cmd(4'b1100, 0, 1, 2, 1'b0, 0, 0);
        bus.ld_en = 1'b1; bus.ld_addr = 2'd0; bus.ld_data = 6'd17;
        get_rsp(3, d, e);
        check("bp_data", d, 13);
        send_cmd(4'b0001, 0, 0, 3, 1'b0, 0, 0);
        get_rsp(0, d, e);
        check("resp_load_ignored", d, 10);

        // Reset while in EXEC
        load_reg(2, 9);
        bus.cmd_valid = 1'b1; bus.cmd_op = 4'b1100; bus.cmd_ra = 2'd2; bus.cmd_rb = 2'd2; bus.cmd_rd = 2'd1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("pre_rst_exec", dbg_state, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREG; i++) m_regs[i] = 0;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        check("mid_rst_alu_sel", bus.alu_sel, 0);
        check("mid_rst_alu_a", bus.alu_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", bus.rsp_valid, 0);
        end
        for (int r = 0; r < NREG; r++) begin
            send_cmd(4'b0001, r, 0, 3, 1'b0, 0, 0);
            get_rsp(0, d, e);
            check("mid_rst_reg_clear", d, 0);
        end

        // Randomized commands against the model
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) load_reg($urandom_range(0, NREG - 1), $urandom_range(0, MOD - 1));
            send_cmd(4'($urandom_range(0, 15)), $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                     $urandom_range(0, NREG - 1), 1'($urandom_range(0, 1)), $urandom_range(0, NREG - 1),
                     $urandom_range(0, MOD - 1));
            get_rsp($urandom_range(0, 2), d, e);
        end
        check("sb_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
